stack_call_ctrl: RTL and testbench
==================================

// Module: stack_call_ctrl
// PURPOSE
//  Subroutine CALL/RET sequencer; the client side of the CPU's 8-entry LIFO stack (push/pop/empty/full/din/dout).
//  Takes single-cycle call/ret requests from the control unit and drives the stack's push/pop/din.
//  Stack dout is registered, so the block captures it one cycle after pop and returns it as ret_pc.
//  Overflow, underflow and conflicting requests are trapped as a sticky fault; the stack is never touched on a fault.
// PARAMETERS
//  WIDTH  8  return-address width; equals the stack data width
//  DEPTH  8  stack capacity; sets the depth-counter range 0..DEPTH
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous, active-high reset
//  call        in   1        CALL request, sampled in IDLE only
//  ret         in   1        RET request, sampled in IDLE only
//  ret_addr    in   WIDTH    address to push on CALL, latched in the accept cycle
//  clr_fault   in   1        leave FAULT state
//  stk_empty   in   1        stack empty flag
//  stk_full    in   1        stack full flag
//  stk_dout    in   WIDTH    stack registered read data
//  stk_push    out  1        stack push strobe, 1 cycle
//  stk_pop     out  1        stack pop strobe, 1 cycle
//  stk_din     out  WIDTH    stack write data
//  busy        out  1        1 whenever state != IDLE
//  done        out  1        1-cycle completion pulse
//  ret_pc      out  WIDTH    popped return address; valid from the done pulse and held until the next RET completes
//  depth       out  clog2(DEPTH+1)  entries pushed and not yet popped
//  fault       out  1        sticky fault flag
//  fault_code  out  2        01 overflow, 10 underflow, 11 call&ret together, 00 none
// BEHAVIOUR
//  - Every output is a register. rst (async) clears all outputs to 0 and the state to IDLE.
//  - Reset mid-operation: stk_push/stk_pop drop in the same instant and the operation is abandoned.
//  - Pair with the stack by driving its active-low reset from ~rst.
//  - States: IDLE, PUSH, POP, CAPT, DONE, FAULT.
//  - Request decode in IDLE at cycle T (priority top-down):
//    - call&ret -> FAULT, code 11.
//    - call & stk_full -> FAULT, code 01.
//    - ret & stk_empty -> FAULT, code 10.
//    - call -> latch ret_addr, go to PUSH.
//    - ret -> go to POP.
//  - CALL: T+1 PUSH drives stk_push=1 with stk_din=latched addr; depth+1 at the end of T+1. T+2 DONE: done=1. T+3 IDLE.
//  - RET: T+1 POP drives stk_pop=1; depth-1 at the end of T+1. T+2 CAPT: stk_dout is valid and loads ret_pc at the edge.
//    T+3 DONE: done=1 and ret_pc holds the new value. T+4 IDLE.
//  - Requests arriving while busy=1 are ignored, not queued. The requester holds off until busy=0.
//  - In the FAULT cycle fault=1, fault_code is set and done stays 0. The stack sees neither push nor pop, so depth is unchanged.
//  - FAULT holds until clr_fault=1. Next cycle: IDLE, fault=0, fault_code=00. call/ret are ignored while in FAULT.
//  - stk_din holds its last value outside PUSH. ret_pc changes only in CAPT.
//  - depth saturates within 0..DEPTH. Overflow and underflow are prevented by the flag checks, never by wrap-around.
// TESTING
//  - Reset: rst=1 mid-POP -> stk_pop=0 immediately; busy, done, fault, depth, ret_pc all 0.
//  - call, ret_addr=0x12 at T -> stk_push=1 and stk_din=0x12 at T+1; done at T+2; depth=1; busy=0 at T+3.
//  - CALL 0x10, 0x20, 0x30, then 3 RETs -> ret_pc 0x30, 0x20, 0x10 at each done (T+3); depth returns to 0.
//  - ret with stk_empty=1 -> fault=1, code 10 at T+1; no stk_pop; clr_fault -> fault=0 the next cycle.
//  - 8 CALLs (stk_full=1), then a 9th call -> code 01; no stk_push; depth stays 8.
//  - call&ret together -> code 11. A call during busy (PUSH state) -> ignored, exactly one push seen.

Source files
------------

// File: rtl/stack_call_ctrl.sv
// CALL/RET sequencer driving an external LIFO stack; captures registered pop data as ret_pc.
// Stack faults (overflow, underflow, call&ret together) trap into a sticky FAULT state.
//
//   state  | meaning
//   IDLE   | waiting for call/ret, decodes request and fault conditions
//   PUSH   | stk_push asserted with latched return address
//   POP    | stk_pop asserted
//   CAPT   | stack read data valid, loaded into ret_pc at the edge
//   DONE   | done pulse
//   FAULT  | sticky fault, left only via clr_fault
module stack_call_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         call,
    input  logic                         ret,
    input  logic [WIDTH-1:0]             ret_addr,
    input  logic                         clr_fault,
    input  logic                         stk_empty,
    input  logic                         stk_full,
    input  logic [WIDTH-1:0]             stk_dout,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [WIDTH-1:0]             stk_din,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             ret_pc,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         fault,
    output logic [1:0]                   fault_code
);

    localparam int DW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_POP   = 3'd2,
        S_CAPT  = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t           state, state_n;
    logic             push_n, pop_n, done_n, busy_n, fault_n;
    logic [WIDTH-1:0] din_n, ret_pc_n;
    logic [DW-1:0]    depth_n;
    logic [1:0]       code_n;

    // Outputs are registered, so next values are computed alongside the next state.
    always_comb begin
        state_n  = state;
        push_n   = 1'b0;
        pop_n    = 1'b0;
        done_n   = 1'b0;
        din_n    = stk_din;
        ret_pc_n = ret_pc;
        depth_n  = depth;
        fault_n  = fault;
        code_n   = fault_code;
        case (state)
            S_IDLE: begin
                if (call && ret) begin
                    state_n = S_FAULT;
                    fault_n = 1'b1;
                    code_n  = 2'b11;
                end else if (call && stk_full) begin
                    state_n = S_FAULT;
                    fault_n = 1'b1;
                    code_n  = 2'b01;
                end else if (ret && stk_empty) begin
                    state_n = S_FAULT;
                    fault_n = 1'b1;
                    code_n  = 2'b10;
                end else if (call) begin
                    state_n = S_PUSH;
                    push_n  = 1'b1;
                    din_n   = ret_addr;
                end else if (ret) begin
                    state_n = S_POP;
                    pop_n   = 1'b1;
                end
            end
            S_PUSH: begin
                state_n = S_DONE;
                done_n  = 1'b1;
                if (depth < DW'(DEPTH))
                    depth_n = depth + DW'(1);
            end
            S_POP: begin
                state_n = S_CAPT;
                if (depth != '0)
                    depth_n = depth - DW'(1);
            end
            S_CAPT: begin
                state_n  = S_DONE;
                done_n   = 1'b1;
                ret_pc_n = stk_dout;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            S_FAULT: begin
                if (clr_fault) begin
                    state_n = S_IDLE;
                    fault_n = 1'b0;
                    code_n  = 2'b00;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            stk_push   <= 1'b0;
            stk_pop    <= 1'b0;
            stk_din    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ret_pc     <= '0;
            depth      <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            state      <= state_n;
            stk_push   <= push_n;
            stk_pop    <= pop_n;
            stk_din    <= din_n;
            busy       <= busy_n;
            done       <= done_n;
            ret_pc     <= ret_pc_n;
            depth      <= depth_n;
            fault      <= fault_n;
            fault_code <= code_n;
        end
    end

endmodule

// File: tb/tb_stack_call_ctrl.sv
// Bench for stack_call_ctrl: a behavioural stack, a transaction-level reference model
// checked every cycle, directed literal checks, then randomized call/ret/clr traffic.
module tb_stack_call_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             call = 1'b0, ret = 1'b0, clr_fault = 1'b0;
    logic [WIDTH-1:0] ret_addr = '0;
    logic             stk_empty, stk_full;
    logic [WIDTH-1:0] stk_dout;
    logic             stk_push, stk_pop, busy, done, fault;
    logic [WIDTH-1:0] stk_din, ret_pc;
    logic [DW-1:0]    depth;
    logic [1:0]       fault_code;

    int n_tests = 0;
    int n_fail  = 0;
    int push_seen = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    stack_call_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .call(call), .ret(ret), .ret_addr(ret_addr),
        .clr_fault(clr_fault), .stk_empty(stk_empty), .stk_full(stk_full),
        .stk_dout(stk_dout), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_din(stk_din), .busy(busy), .done(done), .ret_pc(ret_pc),
        .depth(depth), .fault(fault), .fault_code(fault_code)
    );

    // Behavioural 8-entry stack with registered read data, reset from the same rst.
    logic [WIDTH-1:0] smem [DEPTH];
    logic [3:0]       scnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt     <= 4'd0;
            stk_dout <= '0;
        end else if (stk_push && scnt < 4'(DEPTH)) begin
            smem[scnt[2:0]] <= stk_din;
            scnt            <= scnt + 4'd1;
        end else if (stk_pop && scnt != 4'd0) begin
            stk_dout <= smem[3'(scnt - 4'd1)];
            scnt     <= scnt - 4'd1;
        end
    end
    assign stk_empty = (scnt == 4'd0);
    assign stk_full  = (scnt == 4'(DEPTH));

    // Reference model: which operation is in flight and how many cycles since it was accepted.
    typedef enum {M_IDLE, M_CALL, M_RET, M_FLT} mop_e;
    mop_e             m_op = M_IDLE;
    int               m_age = 0;
    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] m_din = '0, m_ret_pc = '0, m_pend = '0;
    logic [1:0]       m_code = 2'b00;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_op = M_IDLE; m_age = 0; mq.delete();
            m_din = '0; m_ret_pc = '0; m_code = 2'b00;
        end else begin
            case (m_op)
                M_IDLE: begin
                    if (call && ret) begin m_op = M_FLT; m_code = 2'b11; end
                    else if (call && mq.size() == DEPTH) begin m_op = M_FLT; m_code = 2'b01; end
                    else if (ret && mq.size() == 0) begin m_op = M_FLT; m_code = 2'b10; end
                    else if (call) begin m_op = M_CALL; m_age = 1; m_din = ret_addr; end
                    else if (ret) begin m_op = M_RET; m_age = 1; end
                end
                M_CALL: begin
                    if (m_age == 1) begin mq.push_back(m_din); m_age = 2; end
                    else m_op = M_IDLE;
                end
                M_RET: begin
                    if (m_age == 1) m_pend = mq.pop_back();
                    else if (m_age == 2) m_ret_pc = m_pend;
                    if (m_age == 3) m_op = M_IDLE;
                    else m_age++;
                end
                M_FLT: begin
                    if (clr_fault) begin m_op = M_IDLE; m_code = 2'b00; end
                end
                default: m_op = M_IDLE;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (stk_push) push_seen++;
        if (chk_en) begin
            chk("m_push",  32'(stk_push),   32'(m_op == M_CALL && m_age == 1));
            chk("m_pop",   32'(stk_pop),    32'(m_op == M_RET && m_age == 1));
            chk("m_done",  32'(done),       32'((m_op == M_CALL && m_age == 2) || (m_op == M_RET && m_age == 3)));
            chk("m_busy",  32'(busy),       32'(m_op != M_IDLE));
            chk("m_din",   32'(stk_din),    32'(m_din));
            chk("m_retpc", 32'(ret_pc),     32'(m_ret_pc));
            chk("m_depth", 32'(depth),      32'(mq.size()));
            chk("m_fault", 32'(fault),      32'(m_op == M_FLT));
            chk("m_code",  32'(fault_code), 32'(m_code));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic step(input logic c, input logic r, input logic cf, input logic [WIDTH-1:0] a);
        call = c; ret = r; clr_fault = cf; ret_addr = a;
        tick();
        call = 1'b0; ret = 1'b0; clr_fault = 1'b0;
    endtask

    task automatic do_call(input logic [WIDTH-1:0] a);
        step(1'b1, 1'b0, 1'b0, a);
        chk("call_push", 32'(stk_push), 1);
        chk("call_din",  32'(stk_din),  32'(a));
        tick();
        chk("call_done", 32'(done), 1);
        tick();
    endtask

    task automatic do_ret(input logic [WIDTH-1:0] e);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("ret_pop", 32'(stk_pop), 1);
        tick();
        tick();
        chk("ret_done", 32'(done), 1);
        chk("ret_pc",   32'(ret_pc), 32'(e));
        tick();
        chk("ret_idle", 32'(busy), 0);
    endtask

    initial begin
        int p0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy",  32'(busy),   0);
        chk("rst_depth", 32'(depth),  0);
        chk("rst_fault", 32'(fault),  0);
        chk("rst_retpc", 32'(ret_pc), 0);

        // single CALL timing
        step(1'b1, 1'b0, 1'b0, 'h12);
        chk("c12_push", 32'(stk_push), 1);
        chk("c12_din",  32'(stk_din),  'h12);
        chk("c12_busy", 32'(busy),     1);
        tick();
        chk("c12_done",  32'(done),  1);
        chk("c12_depth", 32'(depth), 1);
        tick();
        chk("c12_idle", 32'(busy), 0);
        chk("c12_nodone", 32'(done), 0);
        do_ret('h12);

        // LIFO order
        do_call('h10); do_call('h20); do_call('h30);
        do_ret('h30); do_ret('h20); do_ret('h10);
        chk("lifo_depth", 32'(depth), 0);

        // underflow
        step(1'b0, 1'b1, 1'b0, '0);
        chk("uf_fault", 32'(fault),      1);
        chk("uf_code",  32'(fault_code), 2);
        chk("uf_nopop", 32'(stk_pop),    0);
        chk("uf_nodone", 32'(done),      0);
        step(1'b1, 1'b0, 1'b0, 'h44);
        chk("uf_sticky", 32'(fault), 1);
        step(1'b0, 1'b0, 1'b1, '0);
        chk("uf_clr",      32'(fault),      0);
        chk("uf_clr_code", 32'(fault_code), 0);
        chk("uf_clr_busy", 32'(busy),       0);

        // overflow
        for (int i = 0; i < DEPTH; i++) do_call(8'(i * 17 + 1));
        chk("full_depth", 32'(depth),    8);
        chk("full_flag",  32'(stk_full), 1);
        p0 = push_seen;
        step(1'b1, 1'b0, 1'b0, 'hEE);
        chk("of_code",  32'(fault_code), 1);
        chk("of_depth", 32'(depth),      8);
        tick();
        chk("of_nopush", 32'(push_seen - p0), 0);
        step(1'b0, 1'b0, 1'b1, '0);

        // call & ret together
        step(1'b1, 1'b1, 1'b0, 'h77);
        chk("cr_code",  32'(fault_code), 3);
        chk("cr_fault", 32'(fault),      1);
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = DEPTH - 1; i >= 0; i--) do_ret(8'(i * 17 + 1));

        // call while busy is ignored
        p0 = push_seen;
        step(1'b1, 1'b0, 1'b0, 'hA5);
        call = 1'b1; ret_addr = 'h5A;
        tick();
        call = 1'b0;
        tick();
        chk("busy_pushes", 32'(push_seen - p0), 1);
        chk("busy_depth",  32'(depth),          1);
        chk("busy_din",    32'(stk_din),        'hA5);

        // reset in the middle of a POP
        step(1'b0, 1'b1, 1'b0, '0);
        chk("mid_pop", 32'(stk_pop), 1);
        rst = 1'b1;
        #1;
        chk("rst_pop",   32'(stk_pop), 0);
        chk("rst2_busy", 32'(busy),    0);
        chk("rst2_done", 32'(done),    0);
        chk("rst2_flt",  32'(fault),   0);
        chk("rst2_dep",  32'(depth),   0);
        chk("rst2_pc",   32'(ret_pc),  0);
        @(posedge clk); #1 rst = 1'b0;

        // randomized traffic against the model
        repeat (3000) begin
            call      = ($urandom_range(0, 99) < 35);
            ret       = ($urandom_range(0, 99) < 30);
            clr_fault = ($urandom_range(0, 99) < 25);
            ret_addr  = 8'($urandom);
            tick();
        end
        call = 1'b0; ret = 1'b0; clr_fault = 1'b1;
        repeat (6) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
